// File: rtl/arb_req_source.sv
// arb_req_source
// Requester-side front end for a rotating-priority arbiter. Each client
// pushes transactions into its own small FIFO. The block raises req[i] while
// client i still has an entry that is not already being popped. When the
// registered one-hot gnt[] selects a client, that client's head entry is popped
// and presented, tagged with the client index, on one shared registered bus.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_valid   per-client push request
//   in_ready   per-client "FIFO not full"
//   in_data    client i payload at [i*DATA_W +: DATA_W]
//   req        per-client request to the arbiter
//   gnt        registered grant from the arbiter (one-hot or zero)
//   out_valid  shared output bus carries a transaction this cycle
//   out_id     index of the client that produced out_data
//   out_data   popped payload
//   err        sticky protocol error (multi-bit grant or grant to an empty FIFO)
module arb_req_source #(
  parameter int N_CLIENTS = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLIENTS-1:0]          in_valid,
  output logic [N_CLIENTS-1:0]          in_ready,
  input  logic [N_CLIENTS*DATA_W-1:0]   in_data,
  output logic [N_CLIENTS-1:0]          req,
  input  logic [N_CLIENTS-1:0]          gnt,
  output logic                          out_valid,
  output logic [$clog2(N_CLIENTS)-1:0]  out_id,
  output logic [DATA_W-1:0]             out_data,
  output logic                          err
);

  localparam int ID_W  = $clog2(N_CLIENTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_q  [N_CLIENTS];
  logic [CNT_W-1:0]  count_d  [N_CLIENTS];
  logic [PTR_W-1:0]  wr_ptr_q [N_CLIENTS];
  logic [PTR_W-1:0]  wr_ptr_d [N_CLIENTS];
  logic [PTR_W-1:0]  rd_ptr_q [N_CLIENTS];
  logic [PTR_W-1:0]  rd_ptr_d [N_CLIENTS];
  logic [DATA_W-1:0] mem_q    [N_CLIENTS][DEPTH];
  logic [DATA_W-1:0] mem_d    [N_CLIENTS][DEPTH];

  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_id_q,    out_id_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              err_q,       err_d;

  logic [N_CLIENTS-1:0] push;
  logic [N_CLIENTS-1:0] pop;
  logic                 gnt_multi;
  logic                 gnt_one;
  logic                 gnt_empty;

  // Grant decode and handshake signals. x & (x-1) clears the lowest set
  // bit, so it is non-zero exactly when more than one grant bit is set.
  // req excludes the entry being popped this cycle, so the arbiter can never
  // grant a FIFO that will be empty when that grant arrives.
  always_comb begin
    gnt_multi = (gnt & (gnt - N_CLIENTS'(1))) != '0;
    gnt_one   = (gnt != '0) && !gnt_multi;
    gnt_empty = 1'b0;
    push      = '0;
    pop       = '0;
    in_ready  = '0;
    req       = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      in_ready[i] = (count_q[i] != CNT_W'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
      pop[i]      = gnt_one & gnt[i] & (count_q[i] != '0);
      if (gnt_one && gnt[i] && (count_q[i] == '0)) begin
        gnt_empty = 1'b1;
      end
      req[i] = (count_q[i] - CNT_W'(pop[i])) != '0;
    end
  end

  // FIFO bookkeeping and the registered output stage. Only one client can
  // pop per cycle because pops require a one-hot grant.
  always_comb begin
    mem_d       = mem_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    err_d       = err_q | gnt_multi | gnt_empty;
    for (int i = 0; i < N_CLIENTS; i++) begin
      count_d[i]  = count_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data[i*DATA_W +: DATA_W];
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        out_valid_d = 1'b1;
        out_id_d    = ID_W'(i);
        out_data_d  = mem_q[i][rd_ptr_q[i]];
      end
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Control state; reset wins over any push or grant in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Payload storage needs no reset: a slot is only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: doc/arb_req_source.md
Name: arb_req_source

Overview:
Requester-side front end for the 8-way rotating-priority arbiter. It buffers transactions from N clients in per-client FIFOs and drives req[] to the arbiter. On each registered one-hot gnt[] it pops the winning client's head entry and emits it, tagged with the client id, on a single shared output bus. It sits between the client ports and the shared resource, with the arbiter alongside it closing the req/gnt loop.

Parameters:
N_CLIENTS, 8, number of clients; must match arbiter width.
DATA_W, 8, payload width per transaction.
DEPTH, 4, entries per client FIFO; power of 2, >= 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  N_CLIENTS  per-client push request.
in_ready  out  N_CLIENTS  per-client FIFO not full.
in_data  in  N_CLIENTS*DATA_W  client i payload occupies bits [i*DATA_W +: DATA_W].
req  out  N_CLIENTS  to arbiter; client i has an entry available for a future grant.
gnt  in  N_CLIENTS  from arbiter; registered, one-hot or zero.
out_valid  out  1  registered; shared bus carries a transaction.
out_id  out  $clog2(N_CLIENTS)  index of the granted client.
out_data  out  DATA_W  popped payload.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all FIFOs emptied (count=0, pointers=0). out_valid=0, out_id=0, out_data=0, err=0. Outputs in_ready=all 1s and req=0 follow combinationally.
- FIFO i:
  - push when in_valid[i] & in_ready[i].
  - in_ready[i] = (count_i != DEPTH). No pop-bypass when full.
  - pop when gnt is exactly one-hot at bit i and count_i != 0.
  - simultaneous push+pop: count unchanged, both pointers advance.
  - pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- req[i] = (count_i - pop_i) != 0, combinational from registered count and gnt.
  - The entry being popped this cycle is not re-requested. The arbiter therefore never grants an empty FIFO in the next cycle.
  - This cycle's push is not counted.
- Output stage, registered:
  - on a valid pop at cycle t: out_valid=1, out_id=i, out_data=head_i at t+1.
  - otherwise out_valid=0, and out_id/out_data hold their last values.
  - no backpressure; the downstream consumer always accepts.
- Latency from a push into an empty FIFO at edge t:
  - req high after edge t (count=1);
  - gnt arrives after edge t+1 (arbiter register);
  - out_valid after edge t+2.
  - Back-to-back single-client grants sustain one transaction per cycle once count >= 2.
- Errors: err set and held until rst on either
  - gnt with more than one bit set: no pop occurs;
  - gnt[i] with count_i=0: no pop occurs.
  - In both cases out_valid=0 in the following cycle.
- Ordering: per-client FIFO order is preserved. Cross-client order is set by the arbiter.
- Reset mid-operation: in-flight entries are discarded. A gnt arriving in the cycle rst is high is ignored.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=8'hFF -> in_ready=8'hFF, req=0, out_valid=0, err=0; no push is retained after release.
- Single push: client 3 pushes 8'hA5 at edge t, loop closed with arbiter -> req=8'h08 after t, gnt=8'h08 after t+1, out_valid=1 / out_id=3 / out_data=8'hA5 after t+2. req drops to 0 in the gnt cycle; no second grant occurs.
- Fill/full: push 4 entries 8'h10..8'h13 into client 0 with gnt held 0 -> in_ready[0]=0 after the 4th; a 5th push is ignored. Granting 4 times in consecutive cycles outputs 10,11,12,13 in order, and in_ready[0] returns to 1 after the first pop.
- Round-robin: all 8 clients hold 2 entries (client i data = 8'h(i)0, 8'h(i)1), with the arbiter connected -> out_id cycles 0..7 twice, with each client's x0 before x1, for 16 valid outputs with no gaps and no error.
- Simultaneous push+pop: client 5 at count=2, pushing every cycle while granted every cycle -> count stays 2, in_ready[5] stays 1, output is strict FIFO order.
- Protocol errors: force gnt=8'h06 -> err=1, no pop, out_valid=0. After rst, force gnt=8'h80 with FIFO 7 empty -> err=1, out_valid=0.
